// File: rtl/alu_pipe.sv
// Pipelined ALU: single-cycle logic/arith/shift ops plus an iterative unsigned mul/div/rem engine.
// Latency: 1 cycle for single-cycle ops; WIDTH cycles from the accept edge for MULU/DIVU/REMU.
// Backpressure: result registers hold while out_valid && !out_ready; in_ready drops then and while BUSY.
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Source1,
    input  logic [WIDTH-1:0] Source2,
    input  logic [5:0]       operation,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);

    localparam logic [5:0] OP_ADD  = 6'd27;
    localparam logic [5:0] OP_SUB  = 6'd28;
    localparam logic [5:0] OP_SRL  = 6'd29;
    localparam logic [5:0] OP_SLL  = 6'd30;
    localparam logic [5:0] OP_XOR  = 6'd31;
    localparam logic [5:0] OP_AND  = 6'd32;
    localparam logic [5:0] OP_SLTU = 6'd33;
    localparam logic [5:0] OP_OR   = 6'd34;
    localparam logic [5:0] OP_SRA  = 6'd35;
    localparam logic [5:0] OP_SLT  = 6'd36;
    localparam logic [5:0] OP_MULU = 6'd37;
    localparam logic [5:0] OP_DIVU = 6'd38;
    localparam logic [5:0] OP_REMU = 6'd39;

    localparam logic [1:0] K_MUL = 2'd0;
    localparam logic [1:0] K_DIV = 2'd1;
    localparam logic [1:0] K_REM = 2'd2;

    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nx;
    logic [SHW:0]     cnt;
    logic [1:0]       kind;
    logic [WIDTH-1:0] acc;   // product accumulator / partial remainder
    logic [WIDTH-1:0] opq;   // multiplier / dividend-then-quotient
    logic [WIDTH-1:0] opd;   // multiplicand / divisor

    logic accept, is_iter;
    logic [WIDTH:0]   sum, dif;
    logic [WIDTH-1:0] sc_res;
    logic             sc_carry, sc_ovf, sc_ill;

    logic [WIDTH-1:0] mul_nx, rem_nx, quo_nx, it_res;
    logic [WIDTH:0]   trial, tdiff;
    logic             ge;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_iter  = (operation == OP_MULU) || (operation == OP_DIVU) || (operation == OP_REMU);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && is_iter) state_nx = BUSY;
            BUSY:    if (cnt == CNT_ONE)    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign sum = {1'b0, Source1} + {1'b0, Source2};
    assign dif = {1'b0, Source1} - {1'b0, Source2};

    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_ill   = 1'b0;
        case (operation)
            OP_ADD: begin
                sc_res   = sum[WIDTH-1:0];
                sc_carry = sum[WIDTH];
                sc_ovf   = (Source1[WIDTH-1] == Source2[WIDTH-1]) && (sum[WIDTH-1] != Source1[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res   = dif[WIDTH-1:0];
                sc_carry = dif[WIDTH];
                sc_ovf   = (Source1[WIDTH-1] != Source2[WIDTH-1]) && (dif[WIDTH-1] != Source1[WIDTH-1]);
            end
            OP_SRL:  sc_res = Source1 >> shamt;
            OP_SLL:  sc_res = Source1 << shamt;
            OP_XOR:  sc_res = Source1 ^ Source2;
            OP_AND:  sc_res = Source1 & Source2;
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (Source1 < Source2)};
            OP_OR:   sc_res = Source1 | Source2;
            OP_SRA:  sc_res = $signed(Source1) >>> shamt;
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(Source1) < $signed(Source2))};
            OP_MULU, OP_DIVU, OP_REMU: sc_res = '0;
            default: sc_ill = 1'b1;
        endcase
    end

    // Restoring division: remainder stays below the divisor, so the trial difference fits in WIDTH bits.
    // A zero divisor naturally yields all-ones quotient and remainder == dividend.
    assign mul_nx = acc + (opq[0] ? opd : '0);
    assign trial  = {acc, opq[WIDTH-1]};
    assign tdiff  = trial - {1'b0, opd};
    assign ge     = !tdiff[WIDTH];
    assign rem_nx = ge ? tdiff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_nx = {opq[WIDTH-2:0], ge};

    always_comb begin
        case (kind)
            K_MUL:   it_res = mul_nx;
            K_DIV:   it_res = quo_nx;
            default: it_res = rem_nx;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            kind      <= K_MUL;
            acc       <= '0;
            opq       <= '0;
            opd       <= '0;
            result    <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b0;
        end else if (state == IDLE) begin
            if (accept && is_iter) begin
                out_valid <= 1'b0;
                cnt       <= CNT_INIT;
                acc       <= '0;
                opq       <= Source1;
                opd       <= Source2;
                kind      <= (operation == OP_MULU) ? K_MUL :
                             (operation == OP_DIVU) ? K_DIV : K_REM;
            end else if (accept) begin
                result    <= sc_res;
                zero      <= (sc_res == '0);
                carry     <= sc_carry;
                overflow  <= sc_ovf;
                illegal   <= sc_ill;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end else begin
            cnt <= cnt - CNT_ONE;
            if (kind == K_MUL) begin
                acc <= mul_nx;
                opq <= opq >> 1;
                opd <= opd << 1;
            end else begin
                acc <= rem_nx;
                opq <= quo_nx;
            end
            if (cnt == CNT_ONE) begin
                result    <= it_res;
                zero      <= (it_res == '0);
                carry     <= 1'b0;
                overflow  <= 1'b0;
                illegal   <= 1'b0;
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: a 32-bit instance for most vectors and an 8-bit instance for width checks.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_alu_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] s1, s2, res;
    logic [5:0]  op;
    logic [4:0]  sh;
    logic        zero, carry, ovf, ill;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]  b_s1, b_s2, b_res;
    logic [5:0]  b_op;
    logic [2:0]  b_sh;
    logic        b_zero, b_carry, b_ovf, b_ill;

    alu_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .Source1(s1), .Source2(s2), .operation(op), .shamt(sh),
        .out_valid(out_valid), .out_ready(out_ready), .result(res),
        .zero(zero), .carry(carry), .overflow(ovf), .illegal(ill)
    );

    alu_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .Source1(b_s1), .Source2(b_s2), .operation(b_op), .shamt(b_sh),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .result(b_res),
        .zero(b_zero), .carry(b_carry), .overflow(b_ovf), .illegal(b_ill)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Called on a falling edge; returns on the falling edge where out_valid is first seen.
    // lat counts rising edges after the accept edge; rdy_bad counts BUSY cycles that showed in_ready.
    task automatic run_op(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] s, output int lat, output int rdy_bad);
        int w;
        op = o; s1 = a; s2 = b; sh = s; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("accept32", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        rdy_bad = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_bad++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run8(input logic [5:0] o, input logic [7:0] a, input logic [7:0] b,
                        output int lat);
        int w;
        b_op = o; b_s1 = a; b_s2 = b; b_sh = 3'd0; b_in_valid = 1'b1;
        w = 0;
        while (!b_in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("accept8", b_in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] r;
        logic        c;
        logic        v;
    } vec_t;

    vec_t sv[14];
    vec_t iv[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, rb, nv;

        sv[0]  = '{6'd27, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b1, 1'b0};
        sv[1]  = '{6'd28, 32'h0000_0003, 32'h0000_0005, 5'd0,  32'hFFFF_FFFE, 1'b1, 1'b0};
        sv[2]  = '{6'd36, 32'h8000_0000, 32'h0000_0001, 5'd0,  32'h0000_0001, 1'b0, 1'b0};
        sv[3]  = '{6'd27, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 1'b0, 1'b1};
        sv[4]  = '{6'd35, 32'h8000_0000, 32'h0000_0000, 5'd4,  32'hF800_0000, 1'b0, 1'b0};
        sv[5]  = '{6'd29, 32'h8000_0000, 32'h0000_FFFF, 5'd4,  32'h0800_0000, 1'b0, 1'b0};
        sv[6]  = '{6'd30, 32'h0000_0001, 32'h0000_0000, 5'd31, 32'h8000_0000, 1'b0, 1'b0};
        sv[7]  = '{6'd28, 32'h8000_0000, 32'h0000_0001, 5'd0,  32'h7FFF_FFFF, 1'b0, 1'b1};
        sv[8]  = '{6'd33, 32'h0000_0001, 32'h8000_0000, 5'd0,  32'h0000_0001, 1'b0, 1'b0};
        sv[9]  = '{6'd33, 32'h8000_0000, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b0, 1'b0};
        sv[10] = '{6'd31, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'h0FF0_0FF0, 1'b0, 1'b0};
        sv[11] = '{6'd32, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hF000_F000, 1'b0, 1'b0};
        sv[12] = '{6'd34, 32'hF0F0_F0F0, 32'h0F0F_0000, 5'd0,  32'hFFFF_F0F0, 1'b0, 1'b0};
        sv[13] = '{6'd36, 32'h0000_0001, 32'h8000_0000, 5'd0,  32'h0000_0000, 1'b0, 1'b0};

        iv[0]  = '{6'd37, 32'h0001_2345, 32'h0000_0010, 5'd0,  32'h0012_3450, 1'b0, 1'b0};
        iv[1]  = '{6'd38, 32'd100,       32'd7,         5'd0,  32'd14,        1'b0, 1'b0};
        iv[2]  = '{6'd39, 32'd100,       32'd7,         5'd0,  32'd2,         1'b0, 1'b0};
        iv[3]  = '{6'd38, 32'd5,         32'd0,         5'd0,  32'hFFFF_FFFF, 1'b0, 1'b0};
        iv[4]  = '{6'd39, 32'd5,         32'd0,         5'd0,  32'd5,         1'b0, 1'b0};

        rst_n = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; s1 = '0; s2 = '0; op = '0; sh = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_s1 = '0; b_s2 = '0; b_op = '0; b_sh = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", res, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        // Reset in the middle of a divide, with a nonzero result held from an earlier op.
        run_op(6'd31, 32'h0000_00F0, 32'h0000_000F, 5'd0, lat, rb);
        chk("pre_xor_res", res, 32'h0000_00FF);
        op = 6'd38; s1 = 32'd100; s2 = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_result", res, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_flags", {zero, carry, ovf, ill}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        chk("midrst_no_output", nv, 0);
        chk("midrst_in_ready", in_ready, 1);

        // Back-to-back single-cycle stream, one result per cycle.
        for (int i = 0; i < 14; i++) begin
            op = sv[i].op; s1 = sv[i].a; s2 = sv[i].b; sh = sv[i].sh; in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("s%0d_valid", i), out_valid, 1);
            chk($sformatf("s%0d_res", i), res, sv[i].r);
            chk($sformatf("s%0d_zero", i), zero, (sv[i].r == 32'd0));
            chk($sformatf("s%0d_carry", i), carry, sv[i].c);
            chk($sformatf("s%0d_ovf", i), ovf, sv[i].v);
            chk($sformatf("s%0d_rdy", i), in_ready, 1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_drain", out_valid, 0);

        // Iterative ops.
        for (int i = 0; i < 5; i++) begin
            run_op(iv[i].op, iv[i].a, iv[i].b, 5'd0, lat, rb);
            chk($sformatf("i%0d_lat", i), lat, 32);
            chk($sformatf("i%0d_busy_rdy", i), rb, 0);
            chk($sformatf("i%0d_res", i), res, iv[i].r);
            chk($sformatf("i%0d_cv", i), {carry, ovf, ill}, 3'b000);
        end

        // Backpressure: hold XOR result for 5 cycles with an AND waiting.
        @(negedge clk);
        out_ready = 1'b0;
        run_op(6'd31, 32'h1234_5678, 32'hFFFF_0000, 5'd0, lat, rb);
        chk("bp_xor_lat", lat, 0);
        op = 6'd32; s1 = 32'hFF00_FF00; s2 = 32'h0F0F_0F0F; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_res", i), res, 32'hEDCB_5678);
            chk($sformatf("bp%0d_valid", i), out_valid, 1);
            chk($sformatf("bp%0d_in_ready", i), in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_release_res", res, 32'h0F00_0F00);
        chk("bp_release_valid", out_valid, 1);

        // Illegal opcode right after a nonzero result.
        run_op(6'd50, 32'h1234_5678, 32'h1111_1111, 5'd0, lat, rb);
        chk("ill_res", res, 0);
        chk("ill_flags", {zero, ill, carry, ovf}, 4'b1100);
        chk("ill_lat", lat, 0);

        // 8-bit instance.
        run8(6'd37, 8'h10, 8'h10, lat);
        chk("w8_mul_lat", lat, 8);
        chk("w8_mul_res", b_res, 8'h00);
        chk("w8_mul_zero", b_zero, 1);
        run8(6'd27, 8'hFF, 8'h01, lat);
        chk("w8_add_res", b_res, 8'h00);
        chk("w8_add_cz", {b_carry, b_zero, b_ovf}, 3'b110);
        run8(6'd38, 8'hC8, 8'h07, lat);
        chk("w8_div_lat", lat, 8);
        chk("w8_div_res", b_res, 8'h1C);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
